alu_uart_ctrl: RTL and testbench
================================

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 Param NB_DATA, default 8, operand/result width.
REQ-002 Param NB_CODE, default 6, ALU opcode width.
REQ-003 Param NB_TIMEOUT, default 16, inter-byte timeout counter width.
REQ-004 Param TIMEOUT_TICKS, default 50000, max clock cycles allowed between received bytes of one frame.
REQ-005 i_clk  input  1  single clock; all logic on rising edge.
REQ-006 i_reset  input  1  reset; synchronous, active-low.
REQ-007 i_rx_done  input  1  one-cycle strobe, UART RX byte valid.
REQ-008 i_rx_data  input  NB_DATA  received byte, valid when i_rx_done=1.
REQ-009 o_alu_a  output  NB_DATA  registered operand A to ALU.
REQ-010 o_alu_b  output  NB_DATA  registered operand B to ALU.
REQ-011 o_alu_op  output  NB_CODE  registered opcode to ALU.
REQ-012 i_alu_result  input  NB_DATA  combinational ALU result.
REQ-013 o_tx_start  output  1  one-cycle pulse, start UART TX.
REQ-014 o_tx_data  output  NB_DATA  byte to transmit; stable from o_tx_start until i_tx_done.
REQ-015 i_tx_done  input  1  one-cycle strobe, UART TX finished.
REQ-016 o_busy  output  1  high in every state except GET_A.
REQ-017 o_err_timeout  output  1  one-cycle pulse, frame aborted by timeout.
REQ-018 o_err_opcode  output  1  one-cycle pulse, frame aborted by invalid opcode.
REQ-019 o_overrun  output  1  one-cycle pulse, byte received while unable to accept.

Function
REQ-020 FSM states: GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX; frame = 3 bytes in order A, B, OP.
REQ-021 GET_A: on i_rx_done, o_alu_a<=i_rx_data, go GET_B; no timeout in GET_A.
REQ-022 GET_B: on i_rx_done, o_alu_b<=i_rx_data, go GET_OP.
REQ-023 GET_OP: on i_rx_done, o_alu_op<=i_rx_data[NB_CODE-1:0], go EXEC.
REQ-024 Timeout counter clears on every accepted byte and on entry to GET_A; counts each cycle in GET_B/GET_OP.
REQ-025 In GET_B/GET_OP, counter reaching TIMEOUT_TICKS-1 with i_rx_done=0: pulse o_err_timeout, go GET_A; o_alu_a/b/op keep last values.
REQ-026 Same cycle rx_done and terminal count: byte accepted, no timeout.
REQ-027 Valid opcodes (6-bit): 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL.
REQ-028 OP byte is invalid if any bit above NB_CODE-1 is 1 or low bits not in REQ-027 list.
REQ-029 EXEC (exactly 1 cycle): valid -> o_tx_data<=i_alu_result, go SEND; invalid -> pulse o_err_opcode, go GET_A, no transmission.
REQ-030 SEND (1 cycle): o_tx_start=1, go WAIT_TX; latency: OP rx_done at cycle N -> o_tx_start at N+2.
REQ-031 WAIT_TX: hold o_tx_data; on i_tx_done go GET_A; no timeout.
REQ-032 i_rx_done in EXEC, SEND or WAIT_TX: byte discarded, o_overrun pulses same cycle+1, state unaffected.
REQ-033 i_tx_done outside WAIT_TX is ignored.
REQ-034 Error/start pulses are registered outputs, never high more than 1 consecutive cycle per event.

Reset
REQ-035 i_reset=0 sampled at rising edge: state GET_A, counter 0, o_alu_a/b/op=0, o_tx_data=0, all pulses and o_busy 0.
REQ-036 Reset overrides any state, including mid-frame and WAIT_TX; inputs ignored while i_reset=0.
REQ-037 Reset deasserts: first i_rx_done after release is operand A.

Verification
REQ-038 Rx 0x05, 0x03, 0x20 (ADD), ALU model -> o_tx_start 2 cycles after 3rd strobe, o_tx_data=0x08; i_tx_done -> o_busy=0.
REQ-039 Rx 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE; rx 0x11 during WAIT_TX -> o_overrun pulse, next frame A=0x?? set only after tx_done.
REQ-040 Rx 0x01, 0x02, 0x3F -> o_err_opcode pulse 1 cycle after 3rd strobe, no o_tx_start, state GET_A; repeat with 0xE0 -> same.
REQ-041 TIMEOUT_TICKS=10: rx 0x01 then silence -> o_err_timeout after 10 cycles; next rx 0x07 loads o_alu_a=0x07.
REQ-042 TIMEOUT_TICKS=10: rx_done coincident with terminal count -> accepted, no o_err_timeout.
REQ-043 Reset asserted in GET_OP and again in WAIT_TX -> all outputs 0 next cycle, new frame processed correctly.

Source files
------------

// File: rtl/alu_uart_ctrl_if.sv
// Bus between the UART/ALU frame controller and its surroundings: RX/TX
// handshakes, ALU operands and result, and status pulses.
interface alu_uart_ctrl_if #(
   parameter int unsigned NB_DATA = 8,
   parameter int unsigned NB_CODE = 6
) ();
   logic               i_rx_done;
   logic [NB_DATA-1:0] i_rx_data;
   logic [NB_DATA-1:0] o_alu_a;
   logic [NB_DATA-1:0] o_alu_b;
   logic [NB_CODE-1:0] o_alu_op;
   logic [NB_DATA-1:0] i_alu_result;
   logic               o_tx_start;
   logic [NB_DATA-1:0] o_tx_data;
   logic               i_tx_done;
   logic               o_busy;
   logic               o_err_timeout;
   logic               o_err_opcode;
   logic               o_overrun;

   modport slave (
      input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
      output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
             o_busy, o_err_timeout, o_err_opcode, o_overrun
   );

   modport master (
      output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
      input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
             o_busy, o_err_timeout, o_err_opcode, o_overrun
   );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Collects an A/B/OP byte frame from a UART receiver, drives an external ALU
// and ships the result back through a UART transmitter.
module alu_uart_ctrl #(
   parameter int unsigned NB_DATA       = 8,
   parameter int unsigned NB_CODE       = 6,
   parameter int unsigned NB_TIMEOUT    = 16,
   parameter int unsigned TIMEOUT_TICKS = 50000
) (
   input  logic           i_clk,
   input  logic           i_reset,
   alu_uart_ctrl_if.slave bus
);
   localparam logic [2:0] S_GET_A   = 3'd0;
   localparam logic [2:0] S_GET_B   = 3'd1;
   localparam logic [2:0] S_GET_OP  = 3'd2;
   localparam logic [2:0] S_EXEC    = 3'd3;
   localparam logic [2:0] S_SEND    = 3'd4;
   localparam logic [2:0] S_WAIT_TX = 3'd5;

   localparam logic [NB_TIMEOUT-1:0] CNT_TERM = NB_TIMEOUT'(TIMEOUT_TICKS - 1);

   localparam logic [NB_CODE-1:0] OP_ADD = NB_CODE'(6'b100000);
   localparam logic [NB_CODE-1:0] OP_SUB = NB_CODE'(6'b100010);
   localparam logic [NB_CODE-1:0] OP_AND = NB_CODE'(6'b100100);
   localparam logic [NB_CODE-1:0] OP_OR  = NB_CODE'(6'b100101);
   localparam logic [NB_CODE-1:0] OP_XOR = NB_CODE'(6'b100110);
   localparam logic [NB_CODE-1:0] OP_NOR = NB_CODE'(6'b100111);
   localparam logic [NB_CODE-1:0] OP_SRA = NB_CODE'(6'b000011);
   localparam logic [NB_CODE-1:0] OP_SRL = NB_CODE'(6'b000010);

   logic [2:0]            r_state;
   logic [NB_TIMEOUT-1:0] r_cnt;
   logic [NB_DATA-1:0]    r_alu_a;
   logic [NB_DATA-1:0]    r_alu_b;
   logic [NB_CODE-1:0]    r_alu_op;
   logic                  r_op_valid;
   logic [NB_DATA-1:0]    r_tx_data;
   logic                  r_tx_start;
   logic                  r_busy;
   logic                  r_err_timeout;
   logic                  r_err_opcode;
   logic                  r_overrun;

   logic [2:0]            w_state_nxt;
   logic [NB_TIMEOUT-1:0] w_cnt_nxt;
   logic [NB_DATA-1:0]    w_alu_a_nxt;
   logic [NB_DATA-1:0]    w_alu_b_nxt;
   logic [NB_CODE-1:0]    w_alu_op_nxt;
   logic                  w_op_valid_nxt;
   logic [NB_DATA-1:0]    w_tx_data_nxt;
   logic                  w_tx_start_nxt;
   logic                  w_err_timeout_nxt;
   logic                  w_err_opcode_nxt;
   logic                  w_overrun_nxt;

   logic [NB_CODE-1:0]    w_op_low;
   logic                  w_upper_zero;
   logic                  w_op_valid;
   logic                  w_cnt_term;

   // Opcode is judged on the full received byte, so stray high bits are caught
   assign w_op_low     = bus.i_rx_data[NB_CODE-1:0];
   assign w_upper_zero = ((bus.i_rx_data >> NB_CODE) == '0);
   assign w_op_valid   = w_upper_zero &&
                         ((w_op_low == OP_ADD) || (w_op_low == OP_SUB) ||
                          (w_op_low == OP_AND) || (w_op_low == OP_OR)  ||
                          (w_op_low == OP_XOR) || (w_op_low == OP_NOR) ||
                          (w_op_low == OP_SRA) || (w_op_low == OP_SRL));
   assign w_cnt_term   = (r_cnt == CNT_TERM);

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_alu_a_nxt       = r_alu_a;
      w_alu_b_nxt       = r_alu_b;
      w_alu_op_nxt      = r_alu_op;
      w_op_valid_nxt    = r_op_valid;
      w_tx_data_nxt     = r_tx_data;
      w_tx_start_nxt    = 1'b0;
      w_err_timeout_nxt = 1'b0;
      w_err_opcode_nxt  = 1'b0;
      w_overrun_nxt     = 1'b0;

      case (r_state)
         S_GET_A: begin
            w_cnt_nxt = '0;
            if (bus.i_rx_done) begin
               w_alu_a_nxt = bus.i_rx_data;
               w_state_nxt = S_GET_B;
            end
         end
         S_GET_B: begin
            if (bus.i_rx_done) begin
               w_alu_b_nxt = bus.i_rx_data;
               w_cnt_nxt   = '0;
               w_state_nxt = S_GET_OP;
            end else if (w_cnt_term) begin
               w_err_timeout_nxt = 1'b1;
               w_cnt_nxt         = '0;
               w_state_nxt       = S_GET_A;
            end else begin
               w_cnt_nxt = r_cnt + NB_TIMEOUT'(1);
            end
         end
         S_GET_OP: begin
            if (bus.i_rx_done) begin
               w_alu_op_nxt   = w_op_low;
               w_op_valid_nxt = w_op_valid;
               w_cnt_nxt      = '0;
               w_state_nxt    = S_EXEC;
            end else if (w_cnt_term) begin
               w_err_timeout_nxt = 1'b1;
               w_cnt_nxt         = '0;
               w_state_nxt       = S_GET_A;
            end else begin
               w_cnt_nxt = r_cnt + NB_TIMEOUT'(1);
            end
         end
         S_EXEC: begin
            w_overrun_nxt = bus.i_rx_done;
            if (r_op_valid) begin
               w_tx_data_nxt = bus.i_alu_result;
               w_state_nxt   = S_SEND;
            end else begin
               w_err_opcode_nxt = 1'b1;
               w_state_nxt      = S_GET_A;
            end
         end
         S_SEND: begin
            w_overrun_nxt  = bus.i_rx_done;
            w_tx_start_nxt = 1'b1;
            w_state_nxt    = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            w_overrun_nxt = bus.i_rx_done;
            if (bus.i_tx_done) begin
               w_state_nxt = S_GET_A;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_GET_A;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state       <= S_GET_A;
         r_cnt         <= '0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_op      <= '0;
         r_op_valid    <= 1'b0;
         r_tx_data     <= '0;
         r_tx_start    <= 1'b0;
         r_busy        <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_opcode  <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_alu_a       <= w_alu_a_nxt;
         r_alu_b       <= w_alu_b_nxt;
         r_alu_op      <= w_alu_op_nxt;
         r_op_valid    <= w_op_valid_nxt;
         r_tx_data     <= w_tx_data_nxt;
         r_tx_start    <= w_tx_start_nxt;
         r_busy        <= (w_state_nxt != S_GET_A);
         r_err_timeout <= w_err_timeout_nxt;
         r_err_opcode  <= w_err_opcode_nxt;
         r_overrun     <= w_overrun_nxt;
      end
   end

   assign bus.o_alu_a       = r_alu_a;
   assign bus.o_alu_b       = r_alu_b;
   assign bus.o_alu_op      = r_alu_op;
   assign bus.o_tx_data     = r_tx_data;
   assign bus.o_tx_start    = r_tx_start;
   assign bus.o_busy        = r_busy;
   assign bus.o_err_timeout = r_err_timeout;
   assign bus.o_err_opcode  = r_err_opcode;
   assign bus.o_overrun     = r_overrun;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Scoreboard bench for alu_uart_ctrl: frames, opcode errors, timeouts,
// overruns and resets mid-frame, with a behavioural ALU closing the loop.
module tb_alu_uart_ctrl;
   localparam int K_TX  = 0;
   localparam int K_EOP = 1;
   localparam int K_TO  = 2;
   localparam int K_OVR = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } exp_t;

   logic i_clk;
   logic i_reset;
   int   n_chk;
   int   n_bad;
   exp_t sb_q[$];
   logic prev_start, prev_eop, prev_to, prev_ovr;

   alu_uart_ctrl_if #(.NB_DATA(8), .NB_CODE(6)) bus ();

   alu_uart_ctrl #(
      .NB_DATA(8), .NB_CODE(6), .NB_TIMEOUT(16), .TIMEOUT_TICKS(10)
   ) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
      case (op)
         6'h20:   return 8'(a + b);
         6'h22:   return 8'(a - b);
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h03:   return 8'($signed(a) >>> b);
         6'h02:   return a >> b;
         default: return 8'h00;
      endcase
   endfunction

   function automatic bit op_ok(input logic [7:0] op);
      if (op[7:6] != 2'b00) return 1'b0;
      return op[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
   endfunction

   assign bus.i_alu_result = alu_f(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic sb_pop(input string tag, input int kind, input logic [7:0] data);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk({tag, "_unexpected"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_kind"}, 32'(kind), 32'(e.kind));
         if (kind == K_TX) chk({tag, "_data"}, 32'(data), 32'(e.data));
      end
   endtask

   // Output monitor: every pulse must match the oldest expected event
   always @(negedge i_clk) begin
      if (bus.o_tx_start)    begin chk("start_w", 32'(prev_start), 32'd0); sb_pop("tx", K_TX, bus.o_tx_data); end
      if (bus.o_err_opcode)  begin chk("eop_w", 32'(prev_eop), 32'd0);     sb_pop("eop", K_EOP, 8'h00); end
      if (bus.o_err_timeout) begin chk("to_w", 32'(prev_to), 32'd0);       sb_pop("to", K_TO, 8'h00); end
      if (bus.o_overrun)     begin chk("ovr_w", 32'(prev_ovr), 32'd0);     sb_pop("ovr", K_OVR, 8'h00); end
      prev_start = bus.o_tx_start;
      prev_eop   = bus.o_err_opcode;
      prev_to    = bus.o_err_timeout;
      prev_ovr   = bus.o_overrun;
   end

   task automatic push_exp(input int kind, input logic [7:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge i_clk);
      bus.i_rx_done = 1'b1;
      bus.i_rx_data = d;
      @(negedge i_clk);
      bus.i_rx_done = 1'b0;
      bus.i_rx_data = 8'h00;
   endtask

   task automatic pulse_tx_done();
      @(negedge i_clk);
      bus.i_tx_done = 1'b1;
      @(negedge i_clk);
      bus.i_tx_done = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_a"},     32'(bus.o_alu_a), 32'd0);
      chk({tag, "_b"},     32'(bus.o_alu_b), 32'd0);
      chk({tag, "_op"},    32'(bus.o_alu_op), 32'd0);
      chk({tag, "_txd"},   32'(bus.o_tx_data), 32'd0);
      chk({tag, "_pulse"}, 32'({bus.o_tx_start, bus.o_err_opcode, bus.o_err_timeout, bus.o_overrun}), 32'd0);
      chk({tag, "_busy"},  32'(bus.o_busy), 32'd0);
   endtask

   // Sends OP and checks the fixed EXEC/SEND latency; optionally completes TX
   task automatic op_stage(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input bit done);
      bit         ok;
      logic [7:0] res;
      ok  = op_ok(op);
      res = alu_f(a, b, op[5:0]);
      if (ok) push_exp(K_TX, res);
      else    push_exp(K_EOP, 8'h00);
      send(op);
      @(posedge i_clk); #1;
      chk("lat1_eop", 32'(bus.o_err_opcode), 32'(!ok));
      chk("lat1_start", 32'(bus.o_tx_start), 32'd0);
      @(posedge i_clk); #1;
      chk("lat2_start", 32'(bus.o_tx_start), 32'(ok));
      if (ok) begin
         chk("lat2_txd", 32'(bus.o_tx_data), 32'(res));
         chk("wait_busy", 32'(bus.o_busy), 32'd1);
         if (done) begin
            pulse_tx_done();
            chk("idle_busy", 32'(bus.o_busy), 32'd0);
         end
      end else begin
         chk("eop_busy", 32'(bus.o_busy), 32'd0);
      end
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input bit done);
      send(a);
      send(b);
      op_stage(a, b, op, done);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      n_chk = 0;
      n_bad = 0;
      prev_start = 1'b0; prev_eop = 1'b0; prev_to = 1'b0; prev_ovr = 1'b0;
      i_reset        = 1'b0;
      bus.i_rx_done  = 1'b0;
      bus.i_rx_data  = 8'h00;
      bus.i_tx_done  = 1'b0;
      repeat (3) @(posedge i_clk);
      #1 chk_all_zero("rst");
      @(negedge i_clk) i_reset = 1'b1;

      // Basic ADD and SUB with overrun during WAIT_TX
      run_frame(8'h05, 8'h03, 8'h20, 1'b1);
      run_frame(8'h03, 8'h05, 8'h22, 1'b0);
      push_exp(K_OVR, 8'h00);
      send(8'h11);
      chk("ovr_keep_a", 32'(bus.o_alu_a), 32'h03);
      chk("ovr_busy", 32'(bus.o_busy), 32'd1);
      pulse_tx_done();
      chk("ovr_idle", 32'(bus.o_busy), 32'd0);
      send(8'h21);
      chk("post_ovr_a", 32'(bus.o_alu_a), 32'h21);
      send(8'h01);
      op_stage(8'h21, 8'h01, 8'h20, 1'b1);

      // Invalid opcodes: unknown low bits, then valid low bits with high bits set
      run_frame(8'h01, 8'h02, 8'h3F, 1'b1);
      run_frame(8'h01, 8'h02, 8'hE0, 1'b1);

      // Remaining operations
      run_frame(8'h80, 8'h02, 8'h03, 1'b1);
      run_frame(8'h80, 8'h03, 8'h02, 1'b1);
      run_frame(8'h5A, 8'hFF, 8'h26, 1'b1);
      run_frame(8'h50, 8'h05, 8'h25, 1'b1);
      run_frame(8'hC3, 8'h0F, 8'h24, 1'b1);

      // Timeout after operand A, then a fresh frame starting with A
      send(8'h01);
      push_exp(K_TO, 8'h00);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge i_clk); #1;
         n++;
         if (bus.o_err_timeout) break;
      end
      chk("to_latency", 32'(n), 32'd10);
      chk("to_busy", 32'(bus.o_busy), 32'd0);
      chk("to_keep_a", 32'(bus.o_alu_a), 32'h01);
      send(8'h07);
      chk("to_new_a", 32'(bus.o_alu_a), 32'h07);
      send(8'h02);
      op_stage(8'h07, 8'h02, 8'h20, 1'b1);

      // Byte arriving exactly on the terminal count is accepted
      send(8'h04);
      repeat (8) @(negedge i_clk);
      send(8'h06);
      chk("coin_to", 32'(bus.o_err_timeout), 32'd0);
      chk("coin_b", 32'(bus.o_alu_b), 32'h06);
      op_stage(8'h04, 8'h06, 8'h24, 1'b1);

      // Reset in GET_OP with a byte offered during reset
      send(8'h09);
      send(8'h0A);
      @(negedge i_clk);
      i_reset       = 1'b0;
      bus.i_rx_done = 1'b1;
      bus.i_rx_data = 8'h55;
      @(posedge i_clk); #1;
      chk_all_zero("rst_op");
      @(negedge i_clk);
      bus.i_rx_done = 1'b0;
      i_reset       = 1'b1;
      @(posedge i_clk); #1;
      chk("rst_op_a", 32'(bus.o_alu_a), 32'd0);
      run_frame(8'h0C, 8'h03, 8'h25, 1'b1);

      // Reset in WAIT_TX, stray tx_done ignored, then normal frame
      run_frame(8'h10, 8'h01, 8'h27, 1'b0);
      @(negedge i_clk) i_reset = 1'b0;
      @(posedge i_clk); #1;
      chk_all_zero("rst_wt");
      @(negedge i_clk) i_reset = 1'b1;
      pulse_tx_done();
      chk("stray_done_busy", 32'(bus.o_busy), 32'd0);
      run_frame(8'h33, 8'h11, 8'h22, 1'b1);

      repeat (3) @(negedge i_clk);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
